mul_issue: RTL and testbench
============================

MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 Parameter MUL_LATENCY, default 1, is the cycles from multiplier enable to a valid result; values below 1 SHALL cause an elaboration error.
REQ-002 Parameter TAG_WIDTH, default 5, is the destination-register tag width.
REQ-003 Port clock, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port reset_n, input, 1, is the reset: synchronous and active-low.
REQ-005 Port flush, input, 1, is a synchronous abort of any in-flight operation.
REQ-006 Ports in_valid (input, 1), in_ready (output, 1), in_op1 (input, `DATA_WIDTH), in_op2 (input, `DATA_WIDTH) and in_tag (input, TAG_WIDTH) form the operand request channel.
REQ-007 Ports mul_enable (output, 1), mul_op1 (output, `DATA_WIDTH), mul_op2 (output, `DATA_WIDTH) and mul_result (input, `DATA_WIDTH) connect to the multiplier.
REQ-008 Ports out_valid (output, 1), out_ready (input, 1), out_result (output, `DATA_WIDTH) and out_tag (output, TAG_WIDTH) form the writeback channel.

Function
REQ-009 A handshake SHALL occur only on a rising edge where valid and ready are both high.
REQ-010 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-011 IDLE: in_ready=1; an input handshake SHALL register op1, op2 and tag, clear the latency counter and enter BUSY.
REQ-012 BUSY: mul_enable=1, mul_op1/mul_op2 SHALL hold the registered operands, and the counter SHALL increment each cycle.
REQ-013 In BUSY, on the cycle the counter equals MUL_LATENCY-1, mul_result SHALL be captured into out_result and the FSM SHALL enter DONE.
REQ-014 DONE: out_valid=1, mul_enable=0, and out_result/out_tag SHALL stay stable until an output handshake.
REQ-015 DONE with out_ready=1: in_ready=1; a simultaneous input handshake SHALL go directly to BUSY, otherwise the FSM SHALL go to IDLE.
REQ-016 Input-to-output latency SHALL be: handshake at edge N, out_valid high from cycle N+MUL_LATENCY+1.
REQ-017 At most one operation SHALL be in flight; in_ready=0 in BUSY, and in DONE while out_ready=0.
REQ-018 flush=1 SHALL force IDLE on the next edge from any state and discard the operation with no output; flush SHALL override a same-cycle input handshake, which is not accepted.
REQ-019 The result SHALL be the low `DATA_WIDTH bits of mul_result, unmodified; the block SHALL perform no arithmetic.
REQ-020 The latency counter width SHALL be the ceiling of log2(MUL_LATENCY+1) and SHALL never wrap.

Reset
REQ-021 With reset_n=0 at an edge: state=IDLE, counter=0, out_valid=0, mul_enable=0, mul_op1=mul_op2=0, out_result=0, out_tag=0.
REQ-022 in_ready SHALL be 0 while reset_n=0.
REQ-023 Reset asserted mid-BUSY or mid-DONE SHALL drop the operation; no out_valid SHALL follow.
REQ-024 Reset SHALL take priority over flush and over any handshake.

Configuration
REQ-025 Macro MUL_ISSUE_TAG_EN defined: in_tag is captured with the operands and presented on out_tag.
REQ-026 Macro MUL_ISSUE_TAG_EN undefined: the tag registers SHALL be removed and out_tag SHALL be tied to 0; the port list SHALL stay unchanged.

Structure
REQ-027 DATA_WIDTH, the default TAG_WIDTH, the default MUL_LATENCY and the FSM state encodings SHALL live in the shared ALU package (alu_pkg) used by the multiplier.
REQ-028 The latency counter SHALL be a sub-module, mul_latency_ctr, with inputs clear and run and output done.
REQ-029 The FSM and the registers SHALL remain in mul_issue.

Verification
REQ-030 After reset with MUL_LATENCY=1: issue op1=3, op2=5, tag=7 with out_ready=1 -> out_valid one cycle at N+2 with out_result=15, out_tag=7.
REQ-031 With MUL_LATENCY=4: issue 12*11 while out_ready=0 for 10 cycles -> out_valid from N+5, out_result=132 held stable, in_ready=0 until out_ready rises.
REQ-032 Back-to-back with out_ready=1 and in_valid=1 continuously: 2*2, 3*3, 4*4 -> one result every MUL_LATENCY+1 cycles, with values 4, 9, 16 in order.
REQ-033 Issue 0xF*0xF on 4-bit data -> out_result=0x1 (low bits only).
REQ-034 Flush at BUSY cycle 2, with in_valid=1 in the same cycle -> no out_valid, operand not accepted, in_ready=1 on the next cycle.
REQ-035 reset_n low for one edge during DONE -> out_valid=0 next cycle, all outputs at reset values; a new op then completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, multiplier defaults and issue FSM encodings.
// No logic; constants and types only.
// Consumed by mul_issue and mul_latency_ctr.
package alu_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int DEF_TAG_WIDTH   = 5;
  localparam int DEF_MUL_LATENCY = 1;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

  // Width needed to count 0..lat without wrapping.
  function automatic int mul_ctr_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/mul_latency_ctr.sv
// Counts multiplier cycles; done is high on the cycle the count reaches MUL_LATENCY-1 while running.
// Latency: done is combinational from the registered count and run.
// Backpressure: none; clear wins over run, and the count saturates instead of wrapping.
module mul_latency_ctr
  import alu_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic run,
  output logic done
);

  localparam int              CW   = mul_ctr_width(MUL_LATENCY);
  localparam logic [CW-1:0]   LAST = CW'(MUL_LATENCY - 1);
  localparam logic [CW-1:0]   MAX  = CW'(MUL_LATENCY);

  logic [CW-1:0] count;

  // Restart on a new operation, otherwise advance while the multiplier runs, holding at MAX.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run && (count != MAX)) begin
      count <= count + CW'(1);
    end
  end

  assign done = run && (count == LAST);

endmodule

// File: rtl/mul_issue.sv
// Issues one multiply at a time: captures operands, drives the multiplier, holds the result for writeback.
// Latency: input handshake at edge N gives out_valid after edge N+MUL_LATENCY; one op in flight.
// Backpressure: in_ready low while busy or while a result waits on out_ready; MUL_ISSUE_TAG_EN carries the tag.
module mul_issue
  import alu_pkg::*;
#(
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int TAG_WIDTH   = DEF_TAG_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_op1,
  input  logic [DATA_WIDTH-1:0] in_op2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  mul_enable,
  output logic [DATA_WIDTH-1:0] mul_op1,
  output logic [DATA_WIDTH-1:0] mul_op2,
  input  logic [DATA_WIDTH-1:0] mul_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  if (MUL_LATENCY < 1) begin : g_bad_latency
    $error("mul_issue: MUL_LATENCY must be at least 1");
  end

  mul_state_t state;
  logic       in_fire;
  logic       ctr_run;
  logic       ctr_done;

  // Ready when idle, or when the held result leaves this cycle; never during reset or flush.
  assign in_ready = reset_n && !flush &&
                    ((state == MUL_IDLE) || ((state == MUL_DONE) && out_ready));
  assign in_fire  = in_valid && in_ready;
  assign ctr_run  = (state == MUL_BUSY) && !flush;

  mul_latency_ctr #(
    .MUL_LATENCY(MUL_LATENCY)
  ) u_ctr (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (in_fire),
    .run    (ctr_run),
    .done   (ctr_done)
  );

  // Issue FSM with registered multiplier and writeback outputs; reset beats flush beats handshakes.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= MUL_IDLE;
      mul_enable <= 1'b0;
      mul_op1    <= '0;
      mul_op2    <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      state      <= MUL_IDLE;
      mul_enable <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      case (state)
        MUL_IDLE: begin
          if (in_fire) begin
            mul_op1    <= in_op1;
            mul_op2    <= in_op2;
            mul_enable <= 1'b1;
            state      <= MUL_BUSY;
          end
        end
        MUL_BUSY: begin
          if (ctr_done) begin
            out_result <= mul_result;
            out_valid  <= 1'b1;
            mul_enable <= 1'b0;
            state      <= MUL_DONE;
          end
        end
        MUL_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_fire) begin
              mul_op1    <= in_op1;
              mul_op2    <= in_op2;
              mul_enable <= 1'b1;
              state      <= MUL_BUSY;
            end else begin
              state <= MUL_IDLE;
            end
          end
        end
        default: begin
          state      <= MUL_IDLE;
          mul_enable <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

`ifdef MUL_ISSUE_TAG_EN
  logic [TAG_WIDTH-1:0] tag_q;

  // The tag rides with the operands and only changes when a new operation is accepted.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      tag_q <= '0;
    end else if (in_fire) begin
      tag_q <= in_tag;
    end
  end

  assign out_tag = tag_q;
`else
  logic unused_tag;
  assign unused_tag = ^in_tag;
  assign out_tag    = '0;
`endif

endmodule

// File: tb/tb_mul_issue.sv
// Directed bench for mul_issue: one instance at MUL_LATENCY=1, one at MUL_LATENCY=4.
module tb_mul_issue;
  import alu_pkg::*;

  localparam int TW = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  // Instance A: MUL_LATENCY = 1
  logic                  a_reset_n, a_flush, a_in_valid, a_in_ready;
  logic [DATA_WIDTH-1:0] a_in_op1, a_in_op2, a_mul_op1, a_mul_op2, a_mul_result, a_out_result;
  logic [TW-1:0]         a_in_tag, a_out_tag;
  logic                  a_mul_enable, a_out_valid, a_out_ready;

  // Instance B: MUL_LATENCY = 4
  logic                  b_reset_n, b_flush, b_in_valid, b_in_ready;
  logic [DATA_WIDTH-1:0] b_in_op1, b_in_op2, b_mul_op1, b_mul_op2, b_mul_result, b_out_result;
  logic [TW-1:0]         b_in_tag, b_out_tag;
  logic                  b_mul_enable, b_out_valid, b_out_ready;

  // Multiplier stand-ins: product truncated to the data width.
  assign a_mul_result = a_mul_op1 * a_mul_op2;
  assign b_mul_result = b_mul_op1 * b_mul_op2;

  mul_issue #(.MUL_LATENCY(1), .TAG_WIDTH(TW)) u_a (
    .clock(clock), .reset_n(a_reset_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_op1(a_in_op1), .in_op2(a_in_op2), .in_tag(a_in_tag),
    .mul_enable(a_mul_enable), .mul_op1(a_mul_op1), .mul_op2(a_mul_op2), .mul_result(a_mul_result),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_out_result), .out_tag(a_out_tag)
  );

  mul_issue #(.MUL_LATENCY(4), .TAG_WIDTH(TW)) u_b (
    .clock(clock), .reset_n(b_reset_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_op1(b_in_op1), .in_op2(b_in_op2), .in_tag(b_in_tag),
    .mul_enable(b_mul_enable), .mul_op1(b_mul_op1), .mul_op2(b_mul_op2), .mul_result(b_mul_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result), .out_tag(b_out_tag)
  );

  typedef struct {
    logic [DATA_WIDTH-1:0] op1;
    logic [DATA_WIDTH-1:0] op2;
    logic [TW-1:0]         tag;
    logic [DATA_WIDTH-1:0] exp;
  } vec_t;

  function automatic logic [TW-1:0] exp_tag(input logic [TW-1:0] t);
`ifdef MUL_ISSUE_TAG_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One operation through instance A with out_ready high; lat counts edges after the input handshake.
  task automatic run_a(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y, input logic [TW-1:0] t,
                       output logic [DATA_WIDTH-1:0] res, output logic [TW-1:0] tg, output int lat);
    int w;
    w = 0;
    a_in_op1 = x; a_in_op2 = y; a_in_tag = t; a_in_valid = 1'b1; a_out_ready = 1'b1;
    #1;
    while (!a_in_ready && w < 20) begin step(); w++; end
    step();
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin step(); lat++; end
    res = a_out_result;
    tg  = a_out_tag;
    step();
  endtask

  task automatic run_b(input logic [DATA_WIDTH-1:0] x, input logic [DATA_WIDTH-1:0] y, input logic [TW-1:0] t,
                       output logic [DATA_WIDTH-1:0] res, output logic [TW-1:0] tg, output int lat);
    int w;
    w = 0;
    b_in_op1 = x; b_in_op2 = y; b_in_tag = t; b_in_valid = 1'b1; b_out_ready = 1'b1;
    #1;
    while (!b_in_ready && w < 20) begin step(); w++; end
    step();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin step(); lat++; end
    res = b_out_result;
    tg  = b_out_tag;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t                  vecs[6];
    logic [DATA_WIDTH-1:0] res;
    logic [TW-1:0]         tg;
    int                    lat;
    int                    seen;
    bit                    ok;
    int                    got, cyc, idx;
    bit                    fire;
    int                    tstamp[3];
    logic [DATA_WIDTH-1:0] rres[3];
    logic [DATA_WIDTH-1:0] bb_ops[3];

    vecs[0] = '{op1: 32'd3,          op2: 32'd5,          tag: 5'd7,  exp: 32'd15};
    vecs[1] = '{op1: 32'd0,          op2: 32'd123,        tag: 5'd1,  exp: 32'd0};
    vecs[2] = '{op1: 32'hFFFF_FFFF,  op2: 32'hFFFF_FFFF,  tag: 5'd2,  exp: 32'h1};
    vecs[3] = '{op1: 32'h0001_0000,  op2: 32'h0001_0000,  tag: 5'd3,  exp: 32'h0};
    vecs[4] = '{op1: 32'd1000,       op2: 32'd1000,       tag: 5'd31, exp: 32'd1000000};
    vecs[5] = '{op1: 32'd7,          op2: 32'd6,          tag: 5'd0,  exp: 32'd42};
    bb_ops[0] = 32'd2; bb_ops[1] = 32'd3; bb_ops[2] = 32'd4;

    a_reset_n = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_in_op1 = '0; a_in_op2 = '0; a_in_tag = '0; a_out_ready = 1'b0;
    b_reset_n = 1'b0; b_flush = 1'b0; b_in_valid = 1'b0; b_in_op1 = '0; b_in_op2 = '0; b_in_tag = '0; b_out_ready = 1'b0;

    // Reset state
    step(); step();
    check("reset in_ready low", 64'(a_in_ready), 64'd0);
    check("reset out_valid", 64'(a_out_valid), 64'd0);
    check("reset mul_enable", 64'(a_mul_enable), 64'd0);
    check("reset mul_op1", 64'(a_mul_op1), 64'd0);
    check("reset mul_op2", 64'(a_mul_op2), 64'd0);
    check("reset out_result", 64'(a_out_result), 64'd0);
    check("reset out_tag", 64'(a_out_tag), 64'd0);
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    step();
    check("idle in_ready", 64'(a_in_ready), 64'd1);
    check("idle in_ready B", 64'(b_in_ready), 64'd1);

    // Table vectors on latency-1 instance (first row is the 3*5 tag 7 case)
    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i].op1, vecs[i].op2, vecs[i].tag, res, tg, lat);
      check($sformatf("A vec%0d result", i), 64'(res), 64'(vecs[i].exp));
      check($sformatf("A vec%0d latency", i), 64'(lat), 64'd1);
      check($sformatf("A vec%0d tag", i), 64'(tg), 64'(exp_tag(vecs[i].tag)));
      check($sformatf("A vec%0d single-cycle valid", i), 64'(a_out_valid), 64'd0);
    end

    // Latency 4 with writeback stalled for 10 cycles
    b_out_ready = 1'b0;
    b_in_op1 = 32'd12; b_in_op2 = 32'd11; b_in_tag = 5'd9; b_in_valid = 1'b1;
    step();
    b_in_op1 = 32'd99; b_in_op2 = 32'd99; b_in_tag = 5'd4;
    check("B busy mul_enable", 64'(b_mul_enable), 64'd1);
    check("B busy mul_op1", 64'(b_mul_op1), 64'd12);
    check("B busy mul_op2", 64'(b_mul_op2), 64'd11);
    check("B busy in_ready", 64'(b_in_ready), 64'd0);
    lat = 0;
    while (!b_out_valid && lat < 20) begin step(); lat++; end
    check("B stall latency", 64'(lat), 64'd4);
    check("B stall result", 64'(b_out_result), 64'd132);
    check("B stall tag", 64'(b_out_tag), 64'(exp_tag(5'd9)));
    check("B done mul_enable", 64'(b_mul_enable), 64'd0);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      if (!b_out_valid || b_out_result != 32'd132 || b_in_ready || b_out_tag != exp_tag(5'd9)) ok = 1'b0;
    end
    check("B stall held stable", 64'(ok), 64'd1);
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    #1;
    check("B in_ready on out_ready", 64'(b_in_ready), 64'd1);
    step();
    check("B valid drops after handshake", 64'(b_out_valid), 64'd0);
    check("B stalled op not accepted", 64'(b_mul_enable), 64'd0);

    // Back-to-back 2*2, 3*3, 4*4 with in_valid held high
    got = 0; cyc = 0; idx = 0;
    b_in_op1 = bb_ops[0]; b_in_op2 = bb_ops[0]; b_in_valid = 1'b1;
    #1;
    while (got < 3 && cyc < 60) begin
      fire = b_in_valid && b_in_ready;
      step(); cyc++;
      if (fire) begin
        idx++;
        if (idx < 3) begin b_in_op1 = bb_ops[idx]; b_in_op2 = bb_ops[idx]; end
        else b_in_valid = 1'b0;
      end
      if (b_out_valid) begin tstamp[got] = cyc; rres[got] = b_out_result; got++; end
    end
    check("B2B count", 64'(got), 64'd3);
    check("B2B r0", 64'(rres[0]), 64'd4);
    check("B2B r1", 64'(rres[1]), 64'd9);
    check("B2B r2", 64'(rres[2]), 64'd16);
    check("B2B spacing 0-1", 64'(tstamp[1] - tstamp[0]), 64'd5);
    check("B2B spacing 1-2", 64'(tstamp[2] - tstamp[1]), 64'd5);
    b_in_valid = 1'b0;
    step();

    // Flush on the second BUSY cycle with a competing input request
    b_out_ready = 1'b1;
    b_in_op1 = 32'd5; b_in_op2 = 32'd6; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    step();
    b_flush = 1'b1; b_in_valid = 1'b1; b_in_op1 = 32'd8; b_in_op2 = 32'd8;
    #1;
    check("flush blocks in_ready", 64'(b_in_ready), 64'd0);
    step();
    b_flush = 1'b0; b_in_valid = 1'b0;
    #1;
    check("flush in_ready next cycle", 64'(b_in_ready), 64'd1);
    check("flush mul_enable", 64'(b_mul_enable), 64'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (b_out_valid || b_mul_enable) seen++;
    end
    check("flush no output or issue", 64'(seen), 64'd0);

    // Reset for one edge while a result is waiting
    b_out_ready = 1'b0;
    b_in_op1 = 32'd9; b_in_op2 = 32'd9; b_in_tag = 5'd12; b_in_valid = 1'b1;
    step();
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin step(); lat++; end
    check("pre-reset done", 64'(b_out_valid), 64'd1);
    check("pre-reset result", 64'(b_out_result), 64'd81);
    b_reset_n = 1'b0;
    #1;
    check("in_ready low in reset", 64'(b_in_ready), 64'd0);
    step();
    b_reset_n = 1'b1;
    check("mid-done reset out_valid", 64'(b_out_valid), 64'd0);
    check("mid-done reset mul_enable", 64'(b_mul_enable), 64'd0);
    check("mid-done reset mul_op1", 64'(b_mul_op1), 64'd0);
    check("mid-done reset mul_op2", 64'(b_mul_op2), 64'd0);
    check("mid-done reset out_result", 64'(b_out_result), 64'd0);
    check("mid-done reset out_tag", 64'(b_out_tag), 64'd0);
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (b_out_valid) seen++;
    end
    check("no valid after reset", 64'(seen), 64'd0);
    run_b(32'd6, 32'd7, 5'd21, res, tg, lat);
    check("post-reset result", 64'(res), 64'd42);
    check("post-reset latency", 64'(lat), 64'd4);
    check("post-reset tag", 64'(tg), 64'(exp_tag(5'd21)));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
